pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4, number of carry-chain pipeline segments; SHALL satisfy 1 <= STAGES <= WIDTH and WIDTH % STAGES == 0 (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands/mode valid this cycle.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 in1  input  WIDTH  operand A.
REQ-008 in2  input  WIDTH  operand B.
REQ-009 sub  input  1  0 = add, 1 = subtract.
REQ-010 cin  input  1  carry-in (add) / borrow-in (sub), for multiword chaining.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-015 ovf  output  1  signed two's-complement overflow.
REQ-016 zero  output  1  sum == 0.
REQ-017 neg  output  1  sum[WIDTH-1].

Function
REQ-018 Effective B = sub ? ~in2 : in2; effective carry-in c0 = cin XOR sub; result = in1 + B + c0, modulo 2^WIDTH.
REQ-019 Examples: sub=0,cin=1 -> in1+in2+1; sub=1,cin=0 -> in1-in2; sub=1,cin=1 -> in1-in2-1.
REQ-020 Datapath split into STAGES segments of SEG=WIDTH/STAGES bits; stage k adds bits [k*SEG +: SEG] using the carry registered by stage k-1 (stage 0 uses c0).
REQ-021 Each stage registers its partial sum, carry out, valid bit, and the not-yet-consumed upper operand segments; lower result segments are carried forward unchanged.
REQ-022 ovf = carry into MSB XOR carry out of MSB, computed in the last stage; zero and neg derived from the full registered result.
REQ-023 Global advance = !out_valid || out_ready; in_ready = advance; all stages shift only when advance = 1.
REQ-024 Input accepted on cycle where in_valid && in_ready; with no stall, result is presented with out_valid=1 exactly STAGES cycles later.
REQ-025 Throughput one operation per cycle; results emerge in acceptance order with no loss or duplication.
REQ-026 When out_valid && !out_ready: sum, cout, ovf, zero, neg, out_valid, and all internal stages SHALL hold unchanged.
REQ-027 Bubbles (in_valid=0 while advancing) propagate as invalid stages; out_valid=0 whenever the last stage is empty.
REQ-028 Flag outputs SHALL be meaningful only while out_valid=1; they hold their last value otherwise.
REQ-029 STAGES=1: single registered adder, latency 1, same handshake.
REQ-030 Simultaneous output drain and input accept in the same cycle SHALL both take effect (full-rate flow).

Reset
REQ-031 While reset=1 at a clock edge: all stage valid bits, out_valid, sum, cout, ovf, neg cleared to 0; zero cleared to 0.
REQ-032 Reset mid-operation flushes all in-flight operations; none appear at the output afterwards.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-034 WIDTH=32,STAGES=4, out_ready=1: in1=0xFFFFFFFF,in2=0x00000001,sub=0,cin=0 -> 4 cycles later sum=0,cout=1,zero=1,ovf=0.
REQ-035 in1=0x7FFFFFFF,in2=1,sub=0 -> sum=0x80000000,ovf=1,neg=1,cout=0; in1=5,in2=7,sub=1,cin=0 -> sum=0xFFFFFFFE,cout=0,neg=1.
REQ-036 Back-to-back 16 random ops with out_ready=1 -> 16 consecutive out_valid cycles, results match reference model in order.
REQ-037 Hold out_ready=0 for 10 cycles with pipeline full -> in_ready=0, outputs stable, no ops lost; release -> results resume in order.
REQ-038 Assert reset for one cycle with 3 ops in flight -> out_valid=0 next cycle, no stale results after deassertion.
REQ-039 Repeat REQ-034/036 with STAGES=1 and STAGES=32 -> latency 1 and 32 respectively, results correct.

Source files
------------

// File: rtl/pipe_adder_if.sv
// Handshake and data bundle for pipe_adder: operand/mode inputs with valid/ready,
// and the result with flags and its own valid/ready.
interface pipe_adder_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;
   logic             neg;

   modport master (
      output in_valid, in1, in2, sub, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero, neg
   );

   modport slave (
      input  in_valid, in1, in2, sub, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero, neg
   );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: the WIDTH-bit carry chain is cut into STAGES equal
// segments, one per stage, and the whole pipe advances together under backpressure.
module pipe_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input logic         clk,
   input logic         reset,
   pipe_adder_if.slave io
);
   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipe_adder: WIDTH must be >= 2 and divisible by STAGES (1 <= STAGES <= WIDTH)");
   end

   logic             advance;
   logic [WIDTH-1:0] a_src   [STAGES];
   logic [WIDTH-1:0] b_src   [STAGES];
   logic             c_src   [STAGES];
   logic             v_src   [STAGES];
   logic [WIDTH-1:0] acc_d   [STAGES];
   logic [WIDTH-1:0] acc_q   [STAGES];
   logic [WIDTH-1:0] b_d     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic             carry_d [STAGES];
   logic             carry_q [STAGES];
   logic             valid_d [STAGES];
   logic             valid_q [STAGES];
   logic             ovf_d;
   logic             ovf_q;
   logic             zero_d;
   logic             zero_q;
   logic [SEG:0]     seg_sum;
   logic             msb_carry_in;

   assign advance = !valid_q[LAST] || io.out_ready;

   // acc holds finished result segments below the current stage and still-unused
   // operand A segments above it, so one word per stage carries both.
   always_comb begin
      a_src[0]     = io.in1;
      b_src[0]     = io.sub ? ~io.in2 : io.in2;
      c_src[0]     = io.cin ^ io.sub;
      v_src[0]     = io.in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_src[k] = acc_q[k-1];
         b_src[k] = b_q[k-1];
         c_src[k] = carry_q[k-1];
         v_src[k] = valid_q[k-1];
      end

      seg_sum      = '0;
      msb_carry_in = 1'b0;
      ovf_d        = 1'b0;
      zero_d       = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         seg_sum = {1'b0, a_src[k][k*SEG +: SEG]} + {1'b0, b_src[k][k*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_src[k]};
         acc_d[k]                = a_src[k];
         acc_d[k][k*SEG +: SEG]  = seg_sum[SEG-1:0];
         b_d[k]                  = b_src[k];
         carry_d[k]              = seg_sum[SEG];
         valid_d[k]              = v_src[k];
         if (k == LAST) begin
            msb_carry_in = a_src[k][WIDTH-1] ^ b_src[k][WIDTH-1] ^ seg_sum[SEG-1];
            ovf_d        = msb_carry_in ^ seg_sum[SEG];
            zero_d       = (acc_d[k] == '0);
         end
      end
   end

   // Data registers load only behind a valid token, so bubbles leave the last
   // result and its flags in place while out_valid is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            acc_q[k]   <= '0;
            b_q[k]     <= '0;
            carry_q[k] <= 1'b0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            if (valid_d[k]) begin
               acc_q[k]   <= acc_d[k];
               b_q[k]     <= b_d[k];
               carry_q[k] <= carry_d[k];
            end
         end
         if (valid_d[LAST]) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
         end
      end
   end

   assign io.in_ready  = advance;
   assign io.out_valid = valid_q[LAST];
   assign io.sum       = acc_q[LAST];
   assign io.cout      = carry_q[LAST];
   assign io.ovf       = ovf_q;
   assign io.zero      = zero_q;
   assign io.neg       = acc_q[LAST][WIDTH-1];
endmodule

// File: tb/tb_pipe_adder.sv
// Drives the same operand stream into pipe_adder built with 4, 1 and 32 stages
// and scoreboards each result stream against a reference adder.
module tb_pipe_adder;
   localparam int W = 32;

   typedef struct packed {
      logic [W+3:0] res;
      int           cyc;
   } exp_entry_t;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic [W-1:0] in1;
   logic [W-1:0] in2;
   logic         sub;
   logic         cin;
   logic         out_ready;
   logic [2:0]   out_valid_v;
   logic [2:0]   in_ready_v;
   logic [W+3:0] out_res [3];
   logic [W+3:0] snap    [3];

   int n_compared   = 0;
   int n_mismatched = 0;
   int cyc          = 0;

   exp_entry_t q4[$];
   exp_entry_t q1[$];
   exp_entry_t q32[$];

   for (genvar i = 0; i < 3; i++) begin : g_dut
      localparam int S = (i == 0) ? 4 : ((i == 1) ? 1 : 32);
      pipe_adder_if #(.WIDTH(W)) bus ();
      pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
         .clk   (clk),
         .reset (reset),
         .io    (bus)
      );
      assign bus.in_valid   = in_valid;
      assign bus.in1        = in1;
      assign bus.in2        = in2;
      assign bus.sub        = sub;
      assign bus.cin        = cin;
      assign bus.out_ready  = out_ready;
      assign out_valid_v[i] = bus.out_valid;
      assign in_ready_v[i]  = bus.in_ready;
      assign out_res[i]     = {bus.sum, bus.cout, bus.ovf, bus.zero, bus.neg};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int stages_of(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 1 : 32);
   endfunction

   // Reference: {sum, cout, ovf, zero, neg}; overflow from operand/result signs.
   function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s, input logic c);
      logic [W-1:0] bb;
      logic [W:0]   full;
      logic [W-1:0] r;
      logic         ov;
      bb   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s ^ c};
      r    = full[W-1:0];
      ov   = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
      return {r, full[W], ov, (r == '0), r[W-1]};
   endfunction

   function automatic int q_size(input int d);
      case (d)
         0:       return q4.size();
         1:       return q1.size();
         default: return q32.size();
      endcase
   endfunction

   task automatic push_exp(input int d, input exp_entry_t e);
      case (d)
         0:       q4.push_back(e);
         1:       q1.push_back(e);
         default: q32.push_back(e);
      endcase
   endtask

   task automatic pop_exp(input int d, output exp_entry_t e);
      case (d)
         0:       e = q4.pop_front();
         1:       e = q1.pop_front();
         default: e = q32.pop_front();
      endcase
   endtask

   task automatic compare_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      assert (got === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic checkOutput(input int d, input logic chk_lat);
      exp_entry_t e;
      if (out_valid_v[d] && out_ready) begin
         compare_val($sformatf("s%0d unexpected result", stages_of(d)),
                     64'(q_size(d) != 0), 64'd1);
         if (q_size(d) != 0) begin
            pop_exp(d, e);
            compare_val($sformatf("s%0d result", stages_of(d)), 64'(out_res[d]), 64'(e.res));
            if (chk_lat)
               compare_val($sformatf("s%0d latency", stages_of(d)),
                           64'(cyc - e.cyc), 64'(stages_of(d)));
         end
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic c, input logic ordy,
                                input logic chk_lat);
      exp_entry_t e;
      in_valid  = v;
      in1       = a;
      in2       = b;
      sub       = s;
      cin       = c;
      out_ready = ordy;
      #1;
      for (int d = 0; d < 3; d++) begin
         checkOutput(d, chk_lat);
         compare_val($sformatf("s%0d in_ready", stages_of(d)),
                     64'(in_ready_v[d]), 64'(!out_valid_v[d] || ordy));
         if (v && in_ready_v[d]) begin
            e.res = model(a, b, s, c);
            e.cyc = cyc;
            push_exp(d, e);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_idle(input int n, input logic chk_lat);
      repeat (n) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, chk_lat);
      for (int d = 0; d < 3; d++)
         compare_val($sformatf("s%0d pending after drain", stages_of(d)), 64'(q_size(d)), 64'd0);
   endtask

   task automatic pulse_reset(input int n);
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      q4.delete();
      q1.delete();
      q32.delete();
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in1       = '0;
      in2       = '0;
      sub       = 1'b0;
      cin       = 1'b0;
      out_ready = 1'b1;

      $display("[TB] reset state");
      pulse_reset(3);
      for (int d = 0; d < 3; d++) begin
         compare_val($sformatf("s%0d reset out_valid", stages_of(d)), 64'(out_valid_v[d]), 64'd0);
         compare_val($sformatf("s%0d reset outputs", stages_of(d)), 64'(out_res[d]), 64'd0);
      end
      reset = 1'b0;
      for (int d = 0; d < 3; d++)
         compare_val($sformatf("s%0d in_ready after reset", stages_of(d)), 64'(in_ready_v[d]), 64'd1);

      $display("[TB] directed vectors with latency");
      applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
      run_idle(40, 1'b1);

      $display("[TB] 16 back-to-back random ops");
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b1, 1'b1);
      run_idle(40, 1'b1);

      $display("[TB] fill then stall 10 cycles");
      for (int i = 0; i < 40; i++)
         applyStimulus(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b1, 1'b0);
      for (int i = 0; i < 11; i++) begin
         for (int d = 0; d < 3; d++) begin
            if (i == 0) begin
               snap[d] = out_res[d];
            end else begin
               compare_val($sformatf("s%0d stall hold", stages_of(d)), 64'(out_res[d]), 64'(snap[d]));
               compare_val($sformatf("s%0d stall out_valid", stages_of(d)), 64'(out_valid_v[d]), 64'd1);
               compare_val($sformatf("s%0d stall in_ready", stages_of(d)), 64'(in_ready_v[d]), 64'd0);
            end
         end
         applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      run_idle(40, 1'b0);

      $display("[TB] random valid and backpressure");
      for (int i = 0; i < 80; i++)
         applyStimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) != 0), 1'b0);
      run_idle(40, 1'b0);

      $display("[TB] reset with ops in flight");
      applyStimulus(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h3333_3333, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h4444_4444, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0);
      pulse_reset(1);
      for (int d = 0; d < 3; d++)
         compare_val($sformatf("s%0d flush out_valid", stages_of(d)), 64'(out_valid_v[d]), 64'd0);
      reset = 1'b0;
      for (int d = 0; d < 3; d++)
         compare_val($sformatf("s%0d in_ready after flush", stages_of(d)), 64'(in_ready_v[d]), 64'd1);
      run_idle(40, 1'b0);

      applyStimulus(1'b1, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 1'b1);
      run_idle(40, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
